// File: rtl/mj_ram_console.sv
// Switch-driven RAM console: push-button FSM that saves, reads back and clears a small RAM.
// The button input is synchronised and edge-detected into a single-cycle enter pulse.
//
// state       | meaning
// S_IDLE      | waiting for an opcode on sw[2:0]
// S_SAVE_ADDR | showing sw, next press latches the write address
// S_SAVE_DATA | showing sw, next press writes sw into mem[addr]
// S_READ_ADDR | showing sw, next press latches address and reads the word
// S_READ_SHOW | showing the word read back
// S_CLEAR     | sweeping zeros through the whole RAM, one word per cycle
module mj_ram_console #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int SW_W   = 10
) (
  input  logic              clk_50M,
  input  logic              rst_bar,
  input  logic              enter_bar,
  input  logic [SW_W-1:0]   sw,
  output logic [DATA_W-1:0] disp_val,
  output logic [2:0]        disp_mode,
  output logic [7:0]        LEDG
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_END = DEPTH[ADDR_W:0];

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SAVE_ADDR = 3'd1,
    S_SAVE_DATA = 3'd2,
    S_READ_ADDR = 3'd3,
    S_READ_SHOW = 3'd4,
    S_CLEAR     = 3'd5
  } state_e;

  logic sync1_q, sync2_q, prev_q, armed_q;
  logic [1:0] rdy_q;
  logic enter_pulse;

  // armed_q blocks a pulse from a button that was already held when reset released
  always_ff @(posedge clk_50M or negedge rst_bar) begin
    if (!rst_bar) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rdy_q   <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= ~enter_bar;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rdy_q   <= {rdy_q[0], 1'b1};
      armed_q <= armed_q | (rdy_q[1] & ~sync2_q);
    end
  end

  assign enter_pulse = sync2_q & ~prev_q & armed_q;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [ADDR_W:0]     clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [DATA_W-1:0]   wdata;
  logic [7:0]          led_q, led_d;
  logic [2:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   val_q, val_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rd_data_d = rd_data_q;
    clr_cnt_d = clr_cnt_q;
    we        = 1'b0;
    waddr     = addr_q;
    wdata     = '0;
    case (state_q)
      S_IDLE: begin
        if (enter_pulse) begin
          case (sw[2:0])
            3'd2: state_d = S_SAVE_ADDR;
            3'd3: state_d = S_READ_ADDR;
            3'd4: begin
              state_d   = S_CLEAR;
              we        = 1'b1;
              waddr     = '0;
              clr_cnt_d = (ADDR_W+1)'(1);
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_SAVE_ADDR: begin
        if (enter_pulse) begin
          addr_d  = sw[ADDR_W-1:0];
          state_d = S_SAVE_DATA;
        end
      end
      S_SAVE_DATA: begin
        if (enter_pulse) begin
          we      = 1'b1;
          wdata   = DATA_W'(sw);
          state_d = S_IDLE;
        end
      end
      S_READ_ADDR: begin
        if (enter_pulse) begin
          addr_d    = sw[ADDR_W-1:0];
          rd_data_d = mem_q[sw[ADDR_W-1:0]];
          state_d   = S_READ_SHOW;
        end
      end
      S_READ_SHOW: begin
        if (enter_pulse) state_d = S_IDLE;
      end
      S_CLEAR: begin
        // the counter carries one extra bit so reaching DEPTH never wraps to 0
        if (clr_cnt_q == CNT_END) begin
          state_d = S_IDLE;
        end else begin
          we        = 1'b1;
          waddr     = clr_cnt_q[ADDR_W-1:0];
          clr_cnt_d = clr_cnt_q + (ADDR_W+1)'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    led_d  = 8'h01;
    mode_d = 3'd0;
    val_d  = '0;
    case (state_d)
      S_IDLE:      led_d = 8'h01;
      S_SAVE_ADDR: begin led_d = 8'h02; mode_d = 3'd3; end
      S_SAVE_DATA: begin led_d = 8'h04; mode_d = 3'd3; end
      S_READ_ADDR: begin led_d = 8'h08; mode_d = 3'd3; end
      S_READ_SHOW: begin led_d = 8'h10; mode_d = 3'd6; val_d = rd_data_d; end
      S_CLEAR:     led_d = 8'h20;
      default:     led_d = 8'h01;
    endcase
  end

  always_ff @(posedge clk_50M or negedge rst_bar) begin
    if (!rst_bar) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rd_data_q <= '0;
      clr_cnt_q <= '0;
      led_q     <= 8'h01;
      mode_q    <= 3'd0;
      val_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rd_data_q <= rd_data_d;
      clr_cnt_q <= clr_cnt_d;
      led_q     <= led_d;
      mode_q    <= mode_d;
      val_q     <= val_d;
    end
  end

  // RAM contents survive reset; only CLEAR initialises them
  always_ff @(posedge clk_50M) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign LEDG      = led_q;
  assign disp_mode = mode_q;
  assign disp_val  = val_q;

endmodule

// File: tb/tb_mj_ram_console.sv
// Bench for mj_ram_console: press-level behavioural model checked every cycle,
// directed scenarios with literal expectations, and a small-RAM wide-word instance.
module tb_mj_ram_console;

  logic        clk_50M;
  logic        rst_bar;
  logic        enter_bar, enter2;
  logic [9:0]  sw, sw2;
  logic [15:0] disp_val;
  logic [2:0]  disp_mode, disp_mode2;
  logic [7:0]  LEDG, LEDG2;
  logic [31:0] disp_val2;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  mj_ram_console #(.DATA_W(16), .ADDR_W(4), .SW_W(10)) dut (
    .clk_50M(clk_50M), .rst_bar(rst_bar), .enter_bar(enter_bar), .sw(sw),
    .disp_val(disp_val), .disp_mode(disp_mode), .LEDG(LEDG));

  mj_ram_console #(.DATA_W(32), .ADDR_W(2), .SW_W(10)) dut2 (
    .clk_50M(clk_50M), .rst_bar(rst_bar), .enter_bar(enter2), .sw(sw2),
    .disp_val(disp_val2), .disp_mode(disp_mode2), .LEDG(LEDG2));

  initial begin
    clk_50M = 1'b0;
    forever #5 clk_50M = ~clk_50M;
  end

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0..5 = idle, save-addr, save-data, read-addr, read-show, clear
  int          k, phase, rem;
  bit          p1, p2, p3, s_now, pulse;
  logic [3:0]  maddr;
  logic [15:0] mrd;
  bit          mrd_ok;
  logic [15:0] mmem [16];
  bit          mknown [16];

  initial for (int i = 0; i < 16; i++) mknown[i] = 0;

  always @(posedge clk_50M or negedge rst_bar) begin
    if (!rst_bar) begin
      k = 0; p1 = 0; p2 = 0; p3 = 0;
      phase = 0; rem = 0; maddr = 0; mrd = 0; mrd_ok = 1;
    end else begin
      k++;
      s_now = !enter_bar;
      // a press sampled two edges ago, preceded by a released sample, acts now
      pulse = (k >= 4) && p2 && !p3;
      p3 = p2; p2 = p1; p1 = s_now;
      case (phase)
        0: if (pulse) begin
          if (sw[2:0] == 3'd2) phase = 1;
          else if (sw[2:0] == 3'd3) phase = 3;
          else if (sw[2:0] == 3'd4) begin
            for (int i = 0; i < 16; i++) begin mmem[i] = 0; mknown[i] = 1; end
            rem = 16;
            phase = 5;
          end
        end
        1: if (pulse) begin maddr = sw[3:0]; phase = 2; end
        2: if (pulse) begin mmem[maddr] = {6'd0, sw}; mknown[maddr] = 1; phase = 0; end
        3: if (pulse) begin
          maddr = sw[3:0]; mrd = mmem[sw[3:0]]; mrd_ok = mknown[sw[3:0]]; phase = 4;
        end
        4: if (pulse) phase = 0;
        5: begin rem--; if (rem == 0) phase = 0; end
        default: phase = 0;
      endcase
    end
  end

  function automatic logic [2:0] exp_mode(int ph);
    if (ph == 0 || ph == 5) return 3'd0;
    if (ph == 4) return 3'd6;
    return 3'd3;
  endfunction

  always @(negedge clk_50M) begin
    if (rst_bar && chk_en) begin
      check("model_ledg", {56'd0, LEDG}, 64'd1 << phase);
      check("model_mode", {61'd0, disp_mode}, {61'd0, exp_mode(phase)});
      if (phase != 4 || mrd_ok)
        check("model_val", {48'd0, disp_val}, (phase == 4) ? {48'd0, mrd} : 64'd0);
    end
  end

  task automatic press(bit d2, logic [9:0] v, int hold, int gap);
    @(negedge clk_50M);
    if (d2) begin sw2 = v; enter2 = 1'b0; end
    else begin sw = v; enter_bar = 1'b0; end
    repeat (hold) @(negedge clk_50M);
    if (d2) enter2 = 1'b1; else enter_bar = 1'b1;
    repeat (gap) @(negedge clk_50M);
  endtask

  task automatic p(logic [9:0] v);
    press(0, v, 2, 4);
  endtask

  initial begin
    int cnt, trans;
    bit seen;
    logic [7:0] prev;
    logic [9:0] v;
    int r;

    rst_bar = 1'b1; enter_bar = 1'b1; enter2 = 1'b1; sw = '0; sw2 = '0;
    #1 rst_bar = 1'b0;
    #1;
    check("reset_ledg", {56'd0, LEDG}, 64'h01);
    check("reset_mode", {61'd0, disp_mode}, 64'd0);
    check("reset_val", {48'd0, disp_val}, 64'd0);
    repeat (3) @(negedge clk_50M);
    rst_bar = 1'b1;
    chk_en = 1;
    repeat (4) @(negedge clk_50M);

    p(10'h004);
    repeat (20) @(negedge clk_50M);

    // save then read back
    p(10'h002); p(10'h005); p(10'h2A5); p(10'h003); p(10'h005);
    check("rd_ledg", {56'd0, LEDG}, 64'h10);
    check("rd_mode", {61'd0, disp_mode}, 64'd6);
    check("rd_val", {48'd0, disp_val}, 64'h02A5);
    p(10'h000);

    // clear sweep duration and effect
    p(10'h002); p(10'h00F); p(10'h3FF);
    press(0, 10'h004, 1, 0);
    cnt = 0; seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_50M);
      if (LEDG == 8'h20) begin cnt++; seen = 1; end
      else if (seen) break;
    end
    check("clr_cycles", cnt, 16);
    check("clr_after_ledg", {56'd0, LEDG}, 64'h01);
    p(10'h003); p(10'h00F);
    check("clr_rd_val", {48'd0, disp_val}, 64'd0);
    p(10'h000);

    // long hold gives one transition
    @(negedge clk_50M);
    sw = 10'h002; enter_bar = 1'b0; prev = LEDG; trans = 0;
    repeat (1000) begin
      @(negedge clk_50M);
      if (LEDG !== prev) trans++;
      prev = LEDG;
    end
    enter_bar = 1'b1;
    repeat (4) @(negedge clk_50M);
    check("hold_trans", trans, 1);
    check("hold_ledg", {56'd0, LEDG}, 64'h02);
    p(10'h006); p(10'h111);

    p(10'h007);
    check("bad_op_ledg", {56'd0, LEDG}, 64'h01);

    // async reset during SAVE_DATA
    p(10'h002); p(10'h003); p(10'h0AB);
    p(10'h002); p(10'h003);
    check("sd_ledg", {56'd0, LEDG}, 64'h04);
    @(negedge clk_50M);
    sw = 10'h155;
    #2 rst_bar = 1'b0;
    #1;
    check("arst_ledg", {56'd0, LEDG}, 64'h01);
    check("arst_mode", {61'd0, disp_mode}, 64'd0);
    @(negedge clk_50M); rst_bar = 1'b1;
    repeat (4) @(negedge clk_50M);
    p(10'h003); p(10'h003);
    check("arst_mem", {48'd0, disp_val}, 64'h00AB);
    p(10'h000);

    // button held through reset release
    @(negedge clk_50M);
    sw = 10'h002; enter_bar = 1'b0;
    @(negedge clk_50M); rst_bar = 1'b0;
    @(negedge clk_50M); rst_bar = 1'b1;
    repeat (10) @(negedge clk_50M);
    check("held_rst_ledg", {56'd0, LEDG}, 64'h01);
    enter_bar = 1'b1;
    repeat (4) @(negedge clk_50M);
    p(10'h002);
    check("rearm_ledg", {56'd0, LEDG}, 64'h02);
    p(10'h009); p(10'h0C3);

    // randomized presses
    repeat (200) begin
      v = 10'($urandom_range(0, 1023));
      r = $urandom_range(0, 3);
      if (r == 1) v[2:0] = 3'd2;
      else if (r == 2) v[2:0] = 3'd3;
      else if (r == 3 && $urandom_range(0, 3) == 0) v[2:0] = 3'd4;
      press(0, v, $urandom_range(1, 5), $urandom_range(2, 6));
    end
    repeat (20) @(negedge clk_50M);
    chk_en = 0;

    // small RAM, wide word instance
    press(1, 10'h004, 1, 0);
    cnt = 0; seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_50M);
      if (LEDG2 == 8'h20) begin cnt++; seen = 1; end
      else if (seen) break;
    end
    check("w_clr_cycles", cnt, 4);
    press(1, 10'h002, 2, 4); press(1, 10'h001, 2, 4); press(1, 10'h155, 2, 4);
    press(1, 10'h003, 2, 4); press(1, 10'h001, 2, 4);
    check("w_rd_val", {32'd0, disp_val2}, 64'h0000_0155);
    check("w_rd_mode", {61'd0, disp_mode2}, 64'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
